// File: rtl/mmio_uart_tx_if.sv
// CPU-side memory bus bundle for the serial transmit peripheral.
// The CPU drives the master side; the peripheral takes the slave side.
interface mmio_uart_tx_if;
    logic [31:0] address;
    logic [63:0] data_in;
    logic        mem_write_en;
    logic        mem_read;
    logic [1:0]  size;
    logic [63:0] data_out;
    logic        data_out_en;

    modport master (
        output address, data_in, mem_write_en, mem_read, size,
        input  data_out, data_out_en
    );

    modport slave (
        input  address, data_in, mem_write_en, mem_read, size,
        output data_out, data_out_en
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: TXDATA feeds a small FIFO drained by a
// START/DATA/STOP shifter; STATUS and DIVISOR are readable over the CPU bus.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd16
) (
    input  logic              clock,
    input  logic              reset,
    mmio_uart_tx_if.slave     bus,
    output logic              tx,
    output logic              irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e         state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_q, bit_d;
    logic [15:0]    timer_q, timer_d;
    logic [15:0]    div_lat_q, div_lat_d;
    logic [15:0]    divisor_q, divisor_d;
    logic           ovf_q, ovf_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [7:0]     fifo_q [FIFO_DEPTH];
    logic [7:0]     fifo_d [FIFO_DEPTH];
    logic           tx_q, tx_d;
    logic           irq_q, irq_d;

    logic        hit, wr_tx, wr_div, rd_stat;
    logic        full, empty, push, pop;
    logic [4:0]  offset;
    logic [15:0] div_eff;
    logic [7:0]  count_ext;
    logic [63:0] status;

    always_comb begin
        hit       = bus.address[31:5] == BASE_ADDR[31:5];
        offset    = bus.address[4:0];
        wr_tx     = bus.mem_write_en & hit & (offset == 5'h00);
        wr_div    = bus.mem_write_en & hit & (offset == 5'h10);
        rd_stat   = bus.mem_read & hit & (offset == 5'h08);
        full      = count_q == CW'(FIFO_DEPTH);
        empty     = count_q == '0;
        pop       = (state_q == IDLE) & ~empty;
        // A pop in the same cycle frees a slot, so a write to a full FIFO is still taken.
        push      = wr_tx & (~full | pop);
        div_eff   = (divisor_q == '0) ? 16'd1 : divisor_q;
        count_ext = 8'(count_q);
        status    = {56'b0, count_ext[3:0], ovf_q, empty, full, state_q != IDLE};
    end

    always_comb begin
        bus.data_out_en = bus.mem_read & hit;
        bus.data_out    = '0;
        if (bus.data_out_en) begin
            case (offset)
                5'h08:   bus.data_out = status;
                5'h10:   bus.data_out = {48'b0, divisor_q};
                default: bus.data_out = '0;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        fifo_d   = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = bus.data_in[7:0];
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        ovf_d = ovf_q;
        if (rd_stat) ovf_d = 1'b0;
        if (wr_tx & full & ~pop) ovf_d = 1'b1;

        divisor_d = divisor_q;
        if (wr_div) begin
            if (bus.size == 2'b00) divisor_d[7:0] = bus.data_in[7:0];
            else                   divisor_d      = bus.data_in[15:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        timer_d   = timer_q;
        div_lat_d = div_lat_q;
        tx_d      = 1'b1;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    shift_d   = fifo_q[rd_ptr_q];
                    div_lat_d = div_eff;
                    timer_d   = div_eff - 16'd1;
                    state_d   = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (timer_q == '0) begin
                    timer_d = div_lat_q - 16'd1;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (timer_q == '0) begin
                    timer_d = div_lat_q - 16'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            STOP: begin
                if (timer_q == '0) state_d = IDLE;
                else               timer_d = timer_q - 16'd1;
            end
            default: state_d = IDLE;
        endcase
        irq_d = empty & (state_q == IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_q     <= '0;
            timer_q   <= '0;
            div_lat_q <= 16'd1;
            divisor_q <= DIV_RESET;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            fifo_q    <= '{default: '0};
            tx_q      <= 1'b1;
            irq_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            timer_q   <= timer_d;
            div_lat_q <= div_lat_d;
            divisor_q <= divisor_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            fifo_q    <= fifo_d;
            tx_q      <= tx_d;
            irq_q     <= irq_d;
        end
    end

    assign tx  = tx_q;
    assign irq = irq_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed and random bus traffic against a frame-timing
// reference model; tx and irq are compared every cycle, register reads on demand.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int          DEPTH = 4;
    localparam logic [15:0] DIVR  = 16'd16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic tx, irq;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(DEPTH),
        .DIV_RESET (DIVR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave),
        .tx   (tx),
        .irq  (irq)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model: FIFO contents as a queue, the current frame as (pop edge, divisor, byte).
    // A frame popped at edge p drives start for edges p+1..p+d, eight data bits, stop, and
    // the shifter is idle again after edge p+10d.
    logic [7:0]  q_m[$];
    logic [15:0] div_m;
    bit          ovf_m;
    bit          irq_m;
    bit          fr_valid;
    int          fr_p, fr_d;
    logic [7:0]  fr_byte;

    function automatic bit m_idle_now();
        return !fr_valid || (cyc >= fr_p + 10 * fr_d);
    endfunction

    function automatic logic m_tx();
        int k;
        if (!fr_valid) return 1'b1;
        k = cyc - fr_p - 1;
        if (k < 0)          return 1'b1;
        if (k < fr_d)       return 1'b0;
        if (k < 9 * fr_d)   return fr_byte[(k - fr_d) / fr_d];
        return 1'b1;
    endfunction

    function automatic logic [63:0] m_status();
        logic [3:0] c;
        c = 4'(q_m.size());
        return {56'b0, c, ovf_m, q_m.size() == 0, q_m.size() == DEPTH, !m_idle_now()};
    endfunction

    function automatic logic [63:0] m_read(input logic [4:0] off);
        case (off)
            5'h08:   return m_status();
            5'h10:   return {48'b0, div_m};
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        q_m.delete();
        div_m    = DIVR;
        ovf_m    = 1'b0;
        irq_m    = 1'b1;
        fr_valid = 1'b0;
    endtask

    task automatic model_edge();
        int  e;
        bit  hit, idle_b, pop, full_b, ovf_ev, do_push;
        logic [4:0] off;
        e      = cyc + 1;
        hit    = bus.address[31:5] == BASE[31:5];
        off    = bus.address[4:0];
        idle_b = !fr_valid || (e >= fr_p + 10 * fr_d + 1);
        irq_m  = (q_m.size() == 0) && idle_b;
        pop    = idle_b && (q_m.size() > 0);
        full_b = q_m.size() == DEPTH;
        ovf_ev = 1'b0;
        do_push = 1'b0;
        if (bus.mem_write_en && hit && off == 5'h00) begin
            if (full_b && !pop) ovf_ev = 1'b1;
            else                do_push = 1'b1;
        end
        if (pop) begin
            fr_byte  = q_m.pop_front();
            fr_p     = e;
            fr_d     = (div_m == 0) ? 1 : int'(div_m);
            fr_valid = 1'b1;
        end
        if (do_push) q_m.push_back(bus.data_in[7:0]);
        if (bus.mem_read && hit && off == 5'h08) ovf_m = 1'b0;
        if (ovf_ev) ovf_m = 1'b1;
        if (bus.mem_write_en && hit && off == 5'h10) begin
            if (bus.size == 2'b00) div_m[7:0] = bus.data_in[7:0];
            else                   div_m      = bus.data_in[15:0];
        end
        cyc = e;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check("tx", {63'b0, tx}, {63'b0, m_tx()});
        check("irq", {63'b0, irq}, {63'b0, irq_m});
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input logic [4:0] off, input logic [63:0] data, input logic [1:0] sz);
        bus.address      = BASE | {27'b0, off};
        bus.data_in      = data;
        bus.size         = sz;
        bus.mem_write_en = 1'b1;
        cycle();
        bus.mem_write_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] off);
        bus.address  = BASE | {27'b0, off};
        bus.mem_read = 1'b1;
        #1;
        check({tag, "_en"}, {63'b0, bus.data_out_en}, 64'd1);
        check(tag, bus.data_out, m_read(off));
        cycle();
        bus.mem_read = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30000; i++) begin
            if (q_m.size() == 0 && m_idle_now()) begin
                cycle();
                return;
            end
            cycle();
        end
        check("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        #1 reset = 1'b0;
        #1;
        model_reset();
        check("rst_tx", {63'b0, tx}, 64'd1);
        check("rst_irq", {63'b0, irq}, 64'd1);
        check("rst_oe", {63'b0, bus.data_out_en}, 64'd0);
        check("rst_dout", bus.data_out, 64'd0);
        #1 reset = 1'b1;
    endtask

    initial begin
        bus.address      = '0;
        bus.data_in      = '0;
        bus.size         = '0;
        bus.mem_write_en = 1'b0;
        bus.mem_read     = 1'b0;
        model_reset();
        #23;
        check("por_tx", {63'b0, tx}, 64'd1);
        check("por_irq", {63'b0, irq}, 64'd1);
        check("por_oe", {63'b0, bus.data_out_en}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        cycle();
        rd("status_reset", 5'h08);
        rd("div_reset", 5'h10);

        // Single byte at divisor 4
        wr(5'h10, 64'd4, 2'b10);
        wr(5'h00, 64'hA5, 2'b00);
        drain();

        // Back-to-back writes at divisor 2
        wr(5'h10, 64'd2, 2'b11);
        for (int i = 0; i < 5; i++) wr(5'h00, 64'(8'h30 + i), 2'b00);
        rd("status_b2b", 5'h08);
        drain();

        // Overflow at divisor 100, then sticky-clear on read
        wr(5'h10, 64'd100, 2'b10);
        for (int i = 0; i < 6; i++) wr(5'h00, 64'(8'hC0 + i), 2'b00);
        rd("status_ovf", 5'h08);
        rd("status_ovf_clr", 5'h08);
        drain();

        // Byte-sized divisor write merges into the low byte
        wr(5'h10, 64'h0120, 2'b01);
        wr(5'h10, 64'hFFFF_FFFF_FFFF_FF07, 2'b00);
        rd("div_merge", 5'h10);
        check("div_merge_const", m_read(5'h10), 64'h107);
        wr(5'h10, 64'd0, 2'b10);
        wr(5'h00, 64'h5A, 2'b00);
        drain();

        // Divisor change mid-frame applies to the following frame
        wr(5'h10, 64'd3, 2'b10);
        wr(5'h00, 64'h96, 2'b00);
        wr(5'h00, 64'h3C, 2'b00);
        idle_cycles(8);
        wr(5'h10, 64'd8, 2'b10);
        drain();

        // Reset during a frame with bytes queued
        wr(5'h10, 64'd4, 2'b10);
        wr(5'h00, 64'hE1, 2'b00);
        wr(5'h00, 64'h12, 2'b00);
        wr(5'h00, 64'h34, 2'b00);
        idle_cycles(15);
        apply_reset();
        rd("status_after_rst", 5'h08);
        rd("div_after_rst", 5'h10);
        idle_cycles(60);

        // Other offsets and out-of-window accesses
        wr(5'h18, 64'hFF, 2'b00);
        wr(5'h08, 64'hFF, 2'b00);
        rd("rd_txdata", 5'h00);
        rd("rd_other", 5'h18);
        bus.address  = 32'h1234_0008;
        bus.mem_read = 1'b1;
        #1;
        check("miss_oe", {63'b0, bus.data_out_en}, 64'd0);
        check("miss_dout", bus.data_out, 64'd0);
        cycle();
        bus.mem_read = 1'b0;

        // Random traffic
        wr(5'h10, 64'd2, 2'b10);
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 45)      wr(5'h00, 64'($urandom), 2'($urandom_range(0, 3)));
            else if (r < 52) wr(5'h10, 64'($urandom_range(0, 4)), 2'($urandom_range(0, 3)));
            else if (r < 70) rd("rnd_status", 5'h08);
            else if (r < 75) rd("rnd_div", 5'h10);
            else if (r < 78) wr(5'h18, 64'($urandom), 2'b10);
            else             cycle();
        end
        drain();
        rd("status_final", 5'h08);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
